// File: rtl/fetch_pc.sv
// Program counter and instruction-fetch sequencer: req/ack fetch from instruction
// memory, valid/ready hand-off to decode, and branch/jump/exception redirects.
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_PC   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] seq_pc,
  output logic        if_req,
  output logic [31:0] if_addr,
  input  logic        if_ack,
  input  logic [31:0] if_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        id_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        exc
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] inst_pc_reg, inst_pc_next;
  logic        inst_valid_reg, inst_valid_next;
  logic        if_req_reg, if_req_next;
  logic        pend_valid_reg, pend_valid_next;
  logic        pend_exc_reg, pend_exc_next;
  logic [31:0] pend_target_reg, pend_target_next;

  logic        redir;
  logic [31:0] redir_raw;
  logic [31:0] redir_target;
  logic        keep_pend;

  always_comb begin
    redir        = exc | jmp | br_taken;
    redir_raw    = exc ? EXC_PC : (jmp ? jmp_target : br_target);
    redir_target = redir_raw & ~32'h0000_0003;
    // A pending exception outranks any later jump or branch.
    keep_pend    = pend_valid_reg & pend_exc_reg & ~exc;

    state_next       = state_reg;
    pc_next          = pc_reg;
    inst_next        = inst_reg;
    inst_pc_next     = inst_pc_reg;
    pend_valid_next  = pend_valid_reg;
    pend_exc_next    = pend_exc_reg;
    pend_target_next = pend_target_reg;

    case (state_reg)
      ST_BOOT: begin
        state_next = ST_FETCH;
        if (redir) pc_next = redir_target;
      end
      ST_FETCH: begin
        if (if_ack) begin
          if (pend_valid_reg || redir) begin
            // Word belongs to the stale path; drop it and refetch at the target.
            pc_next         = (redir && !keep_pend) ? redir_target : pend_target_reg;
            pend_valid_next = 1'b0;
            pend_exc_next   = 1'b0;
          end else begin
            inst_next    = if_rdata;
            inst_pc_next = pc_reg;
            state_next   = ST_HOLD;
          end
        end else if (redir) begin
          pend_valid_next = 1'b1;
          if (!keep_pend) begin
            pend_target_next = redir_target;
            pend_exc_next    = exc;
          end
        end
      end
      ST_HOLD: begin
        if (redir) begin
          pc_next    = redir_target;
          state_next = ST_FETCH;
        end else if (id_ready) begin
          pc_next    = seq_pc;
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_BOOT;
    endcase

    if_req_next     = (state_next == ST_FETCH);
    inst_valid_next = (state_next == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_BOOT;
      pc_reg          <= RESET_PC;
      inst_reg        <= 32'h0;
      inst_pc_reg     <= 32'h0;
      inst_valid_reg  <= 1'b0;
      if_req_reg      <= 1'b0;
      pend_valid_reg  <= 1'b0;
      pend_exc_reg    <= 1'b0;
      pend_target_reg <= 32'h0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      inst_reg        <= inst_next;
      inst_pc_reg     <= inst_pc_next;
      inst_valid_reg  <= inst_valid_next;
      if_req_reg      <= if_req_next;
      pend_valid_reg  <= pend_valid_next;
      pend_exc_reg    <= pend_exc_next;
      pend_target_reg <= pend_target_next;
    end
  end

  assign pc         = pc_reg;
  assign if_addr    = pc_reg;
  assign if_req     = if_req_reg;
  assign inst_valid = inst_valid_reg;
  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;

endmodule
